// File: rtl/tis_core.sv
// Single-node TIS-100-style core: one instruction per clock fetched combinationally
// from a 15-word program array, with architectural PC/ACC/BAK held in registers.
module tis_core (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         pLength,
   input  logic [15:0]        prog [0:14],
   output logic [3:0]         pc,
   output logic signed [10:0] acc,
   output logic signed [10:0] bak
);

   function automatic logic signed [11:0] sat12(input logic signed [11:0] v);
      if (v > 12'sd999)
         return 12'sd999;
      else if (v < -12'sd999)
         return -12'sd999;
      else
         return v;
   endfunction

   logic [15:0]        instr;
   logic [3:0]         op;
   logic [11:0]        operand;
   logic [3:0]         len;
   logic [3:0]         last;
   logic signed [11:0] imm;
   logic signed [11:0] src;
   logic signed [11:0] acc_x;
   logic signed [11:0] sum_sat;
   logic signed [11:0] diff_sat;
   logic [4:0]         pc_p1;
   logic [3:0]         pc_seq;
   logic [3:0]         tgt;
   logic signed [12:0] pc_s;
   logic signed [12:0] last_s;
   logic signed [12:0] jro_sum;
   logic [3:0]         jro_pc;
   logic [3:0]         pc_n;
   logic signed [10:0] acc_n;
   logic signed [10:0] bak_n;

   // pc never exceeds 14, but an out-of-range address still decodes as NOP
   always_comb begin
      instr = 16'h0000;
      for (int i = 0; i < 15; i++)
         if (pc == 4'(i))
            instr = prog[i];
   end

   assign op      = instr[15:12];
   assign operand = instr[11:0];
   assign len     = pLength;
   assign last    = len - 4'd1;
   assign acc_x   = {acc[10], acc};
   assign imm     = sat12({operand[10], operand[10:0]});

   always_comb begin
      if (operand[11])
         src = (operand[1:0] == 2'b00) ? acc_x : 12'sd0;
      else
         src = imm;
   end

   // Operands are both within +/-999, so 12-bit sums cannot overflow before clamping
   assign sum_sat  = sat12(acc_x + src);
   assign diff_sat = sat12(acc_x - src);

   assign pc_p1  = {1'b0, pc} + 5'd1;
   assign pc_seq = (pc_p1 >= {1'b0, len}) ? 4'd0 : pc_p1[3:0];
   assign tgt    = (operand[3:0] >= len) ? last : operand[3:0];

   assign pc_s    = {9'd0, pc};
   assign last_s  = {9'd0, last};
   assign jro_sum = pc_s + {src[11], src};

   always_comb begin
      if (jro_sum < 13'sd0)
         jro_pc = 4'd0;
      else if (jro_sum > last_s)
         jro_pc = last;
      else
         jro_pc = jro_sum[3:0];
   end

   // Branch conditions look at acc as it was before this instruction
   always_comb begin
      acc_n = acc;
      bak_n = bak;
      pc_n  = pc_seq;
      case (op)
         4'h1: acc_n = src[10:0];
         4'h3: begin
            acc_n = bak;
            bak_n = acc;
         end
         4'h4: bak_n = acc;
         4'h5: acc_n = sum_sat[10:0];
         4'h6: acc_n = diff_sat[10:0];
         4'h7: acc_n = -acc;
         4'h8: pc_n = tgt;
         4'h9: if (acc == 11'sd0) pc_n = tgt;
         4'hA: if (acc != 11'sd0) pc_n = tgt;
         4'hB: if (acc > 11'sd0) pc_n = tgt;
         4'hC: if (acc < 11'sd0) pc_n = tgt;
         4'hD: pc_n = jro_pc;
         default: ;
      endcase
   end

   // A zero-length program freezes all architectural state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc  <= 4'd0;
         acc <= 11'sd0;
         bak <= 11'sd0;
      end else if (len != 4'd0) begin
         pc  <= pc_n;
         acc <= acc_n;
         bak <= bak_n;
      end
   end

endmodule

// File: tb/tb_tis_core.sv
// Self-checking bench for tis_core: directed programs plus a randomized run
// compared against an integer-arithmetic model of the instruction set.
module tb_tis_core;
   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [3:0]         pLength = 4'd1;
   logic [15:0]        prog [0:14];
   logic [3:0]         pc;
   logic signed [10:0] acc;
   logic signed [10:0] bak;

   int checks = 0;
   int errors = 0;
   int m_pc, m_acc, m_bak;

   tis_core dut (
      .clk     (clk),
      .rst     (rst),
      .pLength (pLength),
      .prog    (prog),
      .pc      (pc),
      .acc     (acc),
      .bak     (bak)
   );

   task automatic tick();
      #1 clk = 1'b1;
      #5 clk = 1'b0;
      #4;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 15; i++) prog[i] = 16'h0000;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #2;
   endtask

   function automatic int clampi(int v, int lo, int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   // Instruction-set model with plain integers; state lives in m_pc/m_acc/m_bak
   task automatic m_step();
      int len, w, op, opd, s, tgt, nacc, nbak, npc;
      len = int'(pLength);
      if (len == 0) return;
      w   = (m_pc < 15) ? int'(prog[m_pc]) : 0;
      op  = w / 4096;
      opd = w % 4096;
      if (opd >= 2048) s = ((opd % 4) == 0) ? m_acc : 0;
      else begin
         s = opd % 2048;
         if (s >= 1024) s = s - 2048;
         s = clampi(s, -999, 999);
      end
      tgt  = opd % 16;
      if (tgt >= len) tgt = len - 1;
      nacc = m_acc;
      nbak = m_bak;
      npc  = (m_pc + 1 >= len) ? 0 : m_pc + 1;
      case (op)
         1:  nacc = s;
         3:  begin nacc = m_bak; nbak = m_acc; end
         4:  nbak = m_acc;
         5:  nacc = clampi(m_acc + s, -999, 999);
         6:  nacc = clampi(m_acc - s, -999, 999);
         7:  nacc = -m_acc;
         8:  npc = tgt;
         9:  if (m_acc == 0) npc = tgt;
         10: if (m_acc != 0) npc = tgt;
         11: if (m_acc > 0) npc = tgt;
         12: if (m_acc < 0) npc = tgt;
         13: npc = clampi(m_pc + s, 0, len - 1);
         default: ;
      endcase
      m_pc  = npc;
      m_acc = nacc;
      m_bak = nbak;
   endtask

   function automatic logic [15:0] rand_word();
      logic [3:0]  op;
      logic [11:0] opd;
      int          v;
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
         0: opd = 12'($urandom);
         1: begin
            v   = int'($urandom_range(0, 60)) - 30;
            opd = {1'b0, 11'(v)};
         end
         default: opd = {1'b1, 9'($urandom), 2'($urandom)};
      endcase
      return {op, opd};
   endfunction

   task automatic test_reset();
      clear_prog();
      pLength = 4'd3;
      rst = 1'b1;
      #2;
      checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
      checks++; if (acc !== 11'sd0) begin errors++; $display("FAIL reset_acc got %0d want 0", acc); end
      checks++; if (bak !== 11'sd0) begin errors++; $display("FAIL reset_bak got %0d want 0", bak); end
      rst = 1'b0;
      #2;
   endtask

   task automatic test_straight_line();
      clear_prog();
      prog[0] = 16'h1005; prog[1] = 16'h5003; prog[2] = 16'h6001;
      pLength = 4'd3;
      pulse_reset();
      tick();
      checks++; if (acc !== 11'sd5) begin errors++; $display("FAIL sl_acc1 got %0d want 5", acc); end
      tick(); tick();
      checks++; if (acc !== 11'sd7) begin errors++; $display("FAIL sl_acc3 got %0d want 7", acc); end
      checks++; if (pc !== 4'd0) begin errors++; $display("FAIL sl_pc3 got %0d want 0", pc); end
      // MOV reloads 5 on the second pass, so it ends at 7 again
      tick(); tick(); tick();
      checks++; if (acc !== 11'sd7 || pc !== 4'd0) begin
         errors++; $display("FAIL sl_pass2 got acc=%0d pc=%0d want acc=7 pc=0", acc, pc);
      end
   endtask

   task automatic test_saturation();
      clear_prog();
      prog[0] = 16'h1384; prog[1] = 16'h50C8; prog[2] = 16'h7000; prog[3] = 16'h60C8;
      pLength = 4'd4;
      pulse_reset();
      tick();
      checks++; if (acc !== 11'sd900) begin errors++; $display("FAIL sat_mov got %0d want 900", acc); end
      tick();
      checks++; if (acc !== 11'sd999) begin errors++; $display("FAIL sat_add got %0d want 999", acc); end
      tick();
      checks++; if (acc !== -11'sd999) begin errors++; $display("FAIL sat_neg got %0d want -999", acc); end
      tick();
      checks++; if (acc !== -11'sd999) begin errors++; $display("FAIL sat_sub got %0d want -999", acc); end
   endtask

   task automatic test_idle();
      clear_prog();
      prog[0] = 16'h1384; prog[1] = 16'h50C8;
      pLength = 4'd4;
      pulse_reset();
      tick();
      pLength = 4'd0;
      tick(); tick(); tick();
      checks++; if (acc !== 11'sd900 || pc !== 4'd1 || bak !== 11'sd0) begin
         errors++; $display("FAIL idle_hold got pc=%0d acc=%0d bak=%0d want pc=1 acc=900 bak=0", pc, acc, bak);
      end
      pLength = 4'd4;
      tick();
      checks++; if (acc !== 11'sd999 || pc !== 4'd2) begin
         errors++; $display("FAIL idle_resume got pc=%0d acc=%0d want pc=2 acc=999", pc, acc);
      end
   endtask

   task automatic test_sav_swp();
      clear_prog();
      prog[0] = 16'h1007; prog[1] = 16'h4000; prog[2] = 16'h17FE; prog[3] = 16'h3000;
      pLength = 4'd4;
      pulse_reset();
      tick(); tick(); tick();
      checks++; if (acc !== -11'sd2 || bak !== 11'sd7) begin
         errors++; $display("FAIL sav_pre got acc=%0d bak=%0d want acc=-2 bak=7", acc, bak);
      end
      tick();
      checks++; if (acc !== 11'sd7) begin errors++; $display("FAIL swp_acc got %0d want 7", acc); end
      checks++; if (bak !== -11'sd2) begin errors++; $display("FAIL swp_bak got %0d want -2", bak); end
   endtask

   task automatic test_branches();
      pLength = 4'd4;
      clear_prog(); prog[0] = 16'h9003; pulse_reset(); tick();
      checks++; if (pc !== 4'd3) begin errors++; $display("FAIL jez_taken got %0d want 3", pc); end
      clear_prog(); prog[0] = 16'hA003; pulse_reset(); tick();
      checks++; if (pc !== 4'd1) begin errors++; $display("FAIL jnz_not got %0d want 1", pc); end
      clear_prog(); prog[2] = 16'hD7FF; pulse_reset(); tick(); tick(); tick();
      checks++; if (pc !== 4'd1) begin errors++; $display("FAIL jro_back got %0d want 1", pc); end
      clear_prog(); prog[1] = 16'hD00A; pulse_reset(); tick(); tick();
      checks++; if (pc !== 4'd3) begin errors++; $display("FAIL jro_clamp got %0d want 3", pc); end
      clear_prog(); prog[0] = 16'h800E; pulse_reset(); tick();
      checks++; if (pc !== 4'd3) begin errors++; $display("FAIL jmp_clamp got %0d want 3", pc); end
      clear_prog(); prog[0] = 16'h17FB; prog[1] = 16'hC003; pulse_reset(); tick(); tick();
      checks++; if (pc !== 4'd3) begin errors++; $display("FAIL jlz_taken got %0d want 3", pc); end
      clear_prog(); prog[0] = 16'h17FB; prog[1] = 16'hB003; pulse_reset(); tick(); tick();
      checks++; if (pc !== 4'd2) begin errors++; $display("FAIL jgz_not got %0d want 2", pc); end
   endtask

   task automatic test_async_reset();
      clear_prog();
      prog[0] = 16'h1005; prog[1] = 16'h5003; prog[2] = 16'h6001;
      pLength = 4'd3;
      pulse_reset();
      tick(); tick();
      checks++; if (acc !== 11'sd8 || pc !== 4'd2) begin
         errors++; $display("FAIL ar_pre got acc=%0d pc=%0d want acc=8 pc=2", acc, pc);
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (pc !== 4'd0 || acc !== 11'sd0 || bak !== 11'sd0) begin
         errors++; $display("FAIL ar_zero got pc=%0d acc=%0d bak=%0d want 0 0 0", pc, acc, bak);
      end
      rst = 1'b0;
      #2;
      tick();
      checks++; if (acc !== 11'sd5 || pc !== 4'd1) begin
         errors++; $display("FAIL ar_resume got acc=%0d pc=%0d want acc=5 pc=1", acc, pc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 15; i++) prog[i] = rand_word();
      pLength = 4'($urandom_range(1, 15));
      pulse_reset();
      m_pc = 0; m_acc = 0; m_bak = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if ($urandom_range(0, 7) == 0) prog[$urandom_range(0, 14)] = rand_word();
         if ($urandom_range(0, 19) == 0) pLength = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            #1;
            m_pc = 0; m_acc = 0; m_bak = 0;
            checks++; if (pc !== 4'd0 || acc !== 11'sd0 || bak !== 11'sd0) begin
               errors++; $display("FAIL rnd_reset cyc=%0d got pc=%0d acc=%0d bak=%0d", cyc, pc, acc, bak);
            end
            rst = 1'b0;
            #1;
         end
         m_step();
         tick();
         checks++; if (int'(pc) !== m_pc) begin
            errors++; $display("FAIL rnd_pc cyc=%0d got %0d want %0d", cyc, pc, m_pc);
         end
         checks++; if (int'(acc) !== m_acc) begin
            errors++; $display("FAIL rnd_acc cyc=%0d got %0d want %0d", cyc, acc, m_acc);
         end
         checks++; if (int'(bak) !== m_bak) begin
            errors++; $display("FAIL rnd_bak cyc=%0d got %0d want %0d", cyc, bak, m_bak);
         end
         // Resync after a mismatch so one fault does not cascade
         if (int'(pc) !== m_pc || int'(acc) !== m_acc || int'(bak) !== m_bak) begin
            m_pc = int'(pc); m_acc = int'(acc); m_bak = int'(bak);
         end
      end
   endtask

   initial begin
      clear_prog();
      test_reset();
      test_straight_line();
      test_saturation();
      test_idle();
      test_sav_swp();
      test_branches();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
